// File: rtl/inst_seq_checker.sv
// Table-driven Inst/Data sequencer for the single-cycle datapath with a Result comparator.
// Optional: define CHECK_MASK_EN to add LoadMask and a per-entry compare mask.
module inst_seq_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GAP   = 0,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             LoadEn,
  input  logic [AW-1:0]    LoadAddr,
  input  logic [WIDTH-1:0] LoadInst,
  input  logic [WIDTH-1:0] LoadData,
  input  logic [WIDTH-1:0] LoadExp,
`ifdef CHECK_MASK_EN
  input  logic [WIDTH-1:0] LoadMask,
`endif
  input  logic [AW:0]      Length,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Loop,
  input  logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Inst,
  output logic [WIDTH-1:0] Data,
  output logic             Busy,
  output logic             Done,
  output logic [AW-1:0]    StepIdx,
  output logic [CNT_W-1:0] ErrCount,
  output logic [AW-1:0]    FirstErrIdx,
  output logic             ErrSeen
);

  localparam int SW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [AW:0]   LEN_ONE  = 1;
  localparam logic [SW-1:0] STEP_END = SW'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] exp_mem  [DEPTH];
`ifdef CHECK_MASK_EN
  logic [WIDTH-1:0] mask_mem [DEPTH];
`endif

  logic [AW:0]   len_q;
  logic [SW-1:0] step_cnt;
  logic [AW-1:0] idx_nxt;
  logic          last_cycle, last_entry, start_go, finish, mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Table storage is never reset; writes are locked out while a run is active.
  always_ff @(posedge Clock) begin
    if (LoadEn && state != S_RUN) begin
      inst_mem[LoadAddr] <= LoadInst;
      data_mem[LoadAddr] <= LoadData;
      exp_mem[LoadAddr]  <= LoadExp;
`ifdef CHECK_MASK_EN
      mask_mem[LoadAddr] <= LoadMask;
`endif
    end
  end

  always_comb begin
`ifdef CHECK_MASK_EN
    mismatch = ((Result ^ exp_mem[StepIdx]) & mask_mem[StepIdx]) != '0;
`else
    mismatch = (Result != exp_mem[StepIdx]);
`endif
  end

  assign last_cycle = (step_cnt == STEP_END);
  assign last_entry = ({1'b0, StepIdx} == (len_q - LEN_ONE));
  assign idx_nxt    = last_entry ? '0 : StepIdx + AW'(1);
  assign start_go   = (state != S_RUN) && Start;
  assign finish     = (state == S_RUN) && (Stop || (last_cycle && last_entry && !Loop));

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (Start) state_nxt = (Length != '0) ? S_RUN : S_DONE;
      S_RUN:          if (finish) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == S_RUN);
    Done = (state == S_DONE);
  end

  // Step sequencing, registered Inst/Data and the error bookkeeping.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Inst        <= '0;
      Data        <= '0;
      StepIdx     <= '0;
      step_cnt    <= '0;
      len_q       <= '0;
      ErrCount    <= '0;
      FirstErrIdx <= '0;
      ErrSeen     <= 1'b0;
    end else if (start_go) begin
      len_q       <= Length;
      StepIdx     <= '0;
      step_cnt    <= '0;
      ErrCount    <= '0;
      FirstErrIdx <= '0;
      ErrSeen     <= 1'b0;
      Inst        <= (Length != '0) ? inst_mem[0] : '0;
      Data        <= (Length != '0) ? data_mem[0] : '0;
    end else if (state == S_RUN) begin
      // A Stop landing on the compare cycle still counts that compare.
      if (last_cycle && mismatch) begin
        ErrCount <= sat_inc(ErrCount);
        if (!ErrSeen) begin
          FirstErrIdx <= StepIdx;
          ErrSeen     <= 1'b1;
        end
      end
      if (finish) begin
        Inst     <= '0;
        Data     <= '0;
        step_cnt <= '0;
      end else if (last_cycle) begin
        step_cnt <= '0;
        StepIdx  <= idx_nxt;
        Inst     <= inst_mem[idx_nxt];
        Data     <= data_mem[idx_nxt];
      end else begin
        step_cnt <= step_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_seq_checker.sv
`timescale 1ns/1ps
// Bench for inst_seq_checker: instances with GAP=0, GAP=2 and CNT_W=2, directed plus randomized runs
// checked against a table-level model of the expected step sequence and error tally.
module tb_inst_seq_checker;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, loop_i, stop_i, stuck;
  logic [AW-1:0]   load_addr;
  logic [W-1:0]    load_inst, load_data, load_exp;
  logic [AW:0]     length;
  logic            start_i [3];
  logic            load_en [3];
  logic [W-1:0]    inst_o [3], data_o [3], res_i [3];
  logic            busy_o [3], done_o [3], seen_o [3];
  logic [AW-1:0]   idx_o [3], fidx_o [3];
  logic [7:0]      ec0, ec1;
  logic [1:0]      ec2;

  logic [W-1:0]    t_inst [D], t_data [D], t_exp [D];
  int n_cmp = 0;
  int n_bad = 0;

  // Stand-in datapath: any fixed function of the presented Inst/Data works.
  function automatic logic [W-1:0] dp(input logic [W-1:0] i, input logic [W-1:0] d);
    return (i + {d[15:0], d[31:16]}) ^ 32'h5A5A_0000;
  endfunction

  assign res_i[0] = stuck ? '0 : dp(inst_o[0], data_o[0]);
  assign res_i[1] = stuck ? '0 : dp(inst_o[1], data_o[1]);
  assign res_i[2] = stuck ? '0 : dp(inst_o[2], data_o[2]);

  inst_seq_checker #(.GAP(0)) d0 (
    .Clock(clk), .Reset(rst), .LoadEn(load_en[0]), .LoadAddr(load_addr),
    .LoadInst(load_inst), .LoadData(load_data), .LoadExp(load_exp),
`ifdef CHECK_MASK_EN
    .LoadMask('1),
`endif
    .Length(length), .Start(start_i[0]), .Stop(stop_i), .Loop(loop_i), .Result(res_i[0]),
    .Inst(inst_o[0]), .Data(data_o[0]), .Busy(busy_o[0]), .Done(done_o[0]), .StepIdx(idx_o[0]),
    .ErrCount(ec0), .FirstErrIdx(fidx_o[0]), .ErrSeen(seen_o[0]));

  inst_seq_checker #(.GAP(2)) d1 (
    .Clock(clk), .Reset(rst), .LoadEn(load_en[1]), .LoadAddr(load_addr),
    .LoadInst(load_inst), .LoadData(load_data), .LoadExp(load_exp),
`ifdef CHECK_MASK_EN
    .LoadMask('1),
`endif
    .Length(length), .Start(start_i[1]), .Stop(stop_i), .Loop(loop_i), .Result(res_i[1]),
    .Inst(inst_o[1]), .Data(data_o[1]), .Busy(busy_o[1]), .Done(done_o[1]), .StepIdx(idx_o[1]),
    .ErrCount(ec1), .FirstErrIdx(fidx_o[1]), .ErrSeen(seen_o[1]));

  inst_seq_checker #(.CNT_W(2)) d2 (
    .Clock(clk), .Reset(rst), .LoadEn(load_en[2]), .LoadAddr(load_addr),
    .LoadInst(load_inst), .LoadData(load_data), .LoadExp(load_exp),
`ifdef CHECK_MASK_EN
    .LoadMask('1),
`endif
    .Length(length), .Start(start_i[2]), .Stop(stop_i), .Loop(loop_i), .Result(res_i[2]),
    .Inst(inst_o[2]), .Data(data_o[2]), .Busy(busy_o[2]), .Done(done_o[2]), .StepIdx(idx_o[2]),
    .ErrCount(ec2), .FirstErrIdx(fidx_o[2]), .ErrSeen(seen_o[2]));

  function automatic logic [7:0] ec(input int s);
    case (s)
      0:       return ec0;
      1:       return ec1;
      default: return {6'b0, ec2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [W-1:0] i, input logic [W-1:0] dd, input logic [W-1:0] e);
    for (int k = 0; k < 3; k++) load_en[k] = 1'b1;
    load_addr = a[AW-1:0];
    load_inst = i;
    load_data = dd;
    load_exp  = e;
    step();
    for (int k = 0; k < 3; k++) load_en[k] = 1'b0;
    t_inst[a] = i;
    t_data[a] = dd;
    t_exp[a]  = e;
  endtask

  // Count of entries among the first len whose datapath result differs from the expectation.
  task automatic model(input int len, output int cnt, output int first);
    logic [W-1:0] r;
    cnt   = 0;
    first = 0;
    for (int k = 0; k < len; k++) begin
      r = stuck ? '0 : dp(t_inst[k], t_data[k]);
      if (r != t_exp[k]) begin
        if (cnt == 0) first = k;
        cnt++;
      end
    end
  endtask

  // One non-looping run; junk loads are attempted throughout and must be ignored.
  task automatic run(input int s, input int len, input string tag);
    int g, raw, first, cap, cyc, e;
    g   = (s == 1) ? 2 : 0;
    cap = (s == 2) ? 3 : 255;
    model(len, raw, first);
    length     = len[AW:0];
    start_i[s] = 1'b1;
    step();
    start_i[s] = 1'b0;
    cyc = len * (1 + g);
    for (int c = 0; c < cyc; c++) begin
      e = c / (1 + g);
      check({tag, ".inst"}, inst_o[s], t_inst[e]);
      check({tag, ".data"}, data_o[s], t_data[e]);
      check({tag, ".busy"}, busy_o[s], 1);
      check({tag, ".idx"},  idx_o[s], e);
      load_en[s] = 1'b1;
      load_addr  = AW'($urandom_range(D - 1));
      load_inst  = $urandom;
      load_data  = $urandom;
      load_exp   = $urandom;
      step();
    end
    load_en[s] = 1'b0;
    check({tag, ".end_busy"}, busy_o[s], 0);
    check({tag, ".end_done"}, done_o[s], 1);
    check({tag, ".end_inst"}, inst_o[s], 0);
    check({tag, ".end_data"}, data_o[s], 0);
    check({tag, ".errcount"}, ec(s), (raw > cap) ? cap : raw);
    check({tag, ".firsterr"}, fidx_o[s], (raw > 0) ? first : 0);
    check({tag, ".errseen"},  seen_o[s], (raw > 0) ? 1 : 0);
  endtask

  initial begin
    int len, s;
    logic [W-1:0] pi [5];
    logic [W-1:0] pd [5];
    logic [W-1:0] pe [5];
    logic [W-1:0] ri, rd, re;
    pi[0] = 32'h0000_2820; pd[0] = 32'd0;  pe[0] = 32'd0;
    pi[1] = 32'h8CB1_0000; pd[1] = 32'd10; pe[1] = 32'd0;
    pi[2] = 32'h8CB2_0004; pd[2] = 32'd5;  pe[2] = 32'd4;
    pi[3] = 32'h0232_9822; pd[3] = 32'd0;  pe[3] = 32'd5;
    pi[4] = 32'h0232_8820; pd[4] = 32'd0;  pe[4] = 32'd15;

    rst = 1'b1; loop_i = 1'b0; stop_i = 1'b0; stuck = 1'b0;
    load_addr = '0; load_inst = '0; load_data = '0; load_exp = '0; length = '0;
    for (int k = 0; k < 3; k++) begin start_i[k] = 1'b0; load_en[k] = 1'b0; end
    step(); step();
    check("rst.inst", inst_o[0], 0);
    check("rst.data", data_o[0], 0);
    check("rst.busy", busy_o[0], 0);
    check("rst.done", done_o[0], 0);
    check("rst.idx",  idx_o[0], 0);
    check("rst.ec",   ec(0), 0);
    check("rst.fidx", fidx_o[0], 0);
    check("rst.seen", seen_o[0], 0);
    rst = 1'b0;
    step();

    // Five-entry program, all results matching.
    for (int k = 0; k < 5; k++) load(k, pi[k], pd[k], dp(pi[k], pd[k]));
    run(0, 5, "match");
    load(3, pi[3], pd[3], dp(pi[3], pd[3]) ^ 32'h1);
    run(0, 5, "bad3");
    // Literal expected values, Result stuck at zero.
    for (int k = 0; k < 5; k++) load(k, pi[k], pd[k], pe[k]);
    stuck = 1'b1;
    run(0, 5, "stuck0");
    stuck = 1'b0;
    run(1, 3, "gap2");

    // Looping run, entry 1 bad; Stop lands on a compare cycle after four passes.
    load(0, pi[0], pd[0], dp(pi[0], pd[0]));
    load(1, pi[1], pd[1], dp(pi[1], pd[1]) ^ 32'h80);
    loop_i = 1'b1; length = 2; start_i[0] = 1'b1;
    step();
    start_i[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("loop.idx",  idx_o[0], c % 2);
      check("loop.inst", inst_o[0], t_inst[c % 2]);
      step();
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0; loop_i = 1'b0;
    check("loop.busy", busy_o[0], 0);
    check("loop.done", done_o[0], 1);
    check("loop.inst", inst_o[0], 0);
    check("loop.ec",   ec(0), 4);
    check("loop.fidx", fidx_o[0], 1);
    check("loop.seen", seen_o[0], 1);

    // Stop before the compare cycle skips the compare; on the compare cycle it counts.
    stuck = 1'b1; length = 3;
    start_i[1] = 1'b1; step(); start_i[1] = 1'b0;
    step();
    stop_i = 1'b1; step(); stop_i = 1'b0;
    check("stop_early.done", done_o[1], 1);
    check("stop_early.ec",   ec(1), 0);
    start_i[1] = 1'b1; step(); start_i[1] = 1'b0;
    step(); step();
    stop_i = 1'b1; step(); stop_i = 1'b0;
    check("stop_cmp.done", done_o[1], 1);
    check("stop_cmp.inst", inst_o[1], 0);
    check("stop_cmp.ec",   ec(1), (t_exp[0] != 0) ? 1 : 0);

    // Zero-length start.
    length = 0; start_i[0] = 1'b1; step(); start_i[0] = 1'b0;
    check("len0.done", done_o[0], 1);
    check("len0.busy", busy_o[0], 0);
    check("len0.inst", inst_o[0], 0);
    check("len0.ec",   ec(0), 0);
    check("len0.seen", seen_o[0], 0);
    step();
    check("len0.inst_hold", inst_o[0], 0);
    check("len0.done_hold", done_o[0], 1);

    // Reset in the middle of a run, then rerun from the retained table.
    for (int k = 0; k < 5; k++) load(k, pi[k], pd[k], dp(pi[k], pd[k]) | 32'h1);
    length = 5; start_i[0] = 1'b1; step(); start_i[0] = 1'b0;
    step(); step();
    check("midrst.idx_before", idx_o[0], 2);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst.inst", inst_o[0], 0);
    check("midrst.busy", busy_o[0], 0);
    check("midrst.done", done_o[0], 0);
    check("midrst.ec",   ec(0), 0);
    check("midrst.seen", seen_o[0], 0);
    check("midrst.idx",  idx_o[0], 0);
    stuck = 1'b0;
    run(0, 5, "rerun");

    // Saturating counter on the narrow instance.
    for (int k = 0; k < 5; k++) load(k, pi[k], pd[k], 32'h100 + k);
    stuck = 1'b1;
    run(2, 5, "sat");
    check("sat.ec_cap", ec(2), 3);
    stuck = 1'b0;

    // Randomized tables, lengths and instances.
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < D; k++) begin
        ri = $urandom;
        rd = $urandom;
        re = dp(ri, rd);
        if ($urandom_range(2) == 0) re = re ^ (32'h1 << $urandom_range(31));
        load(k, ri, rd, re);
      end
      s     = $urandom_range(2);
      len   = $urandom_range(D, 1);
      stuck = ($urandom_range(7) == 0);
      run(s, len, "rand");
      stuck = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
